// File: rtl/lib_rtl_pkg.sv
// Shared types and parameter limits for the lib_rtl arithmetic blocks.
package lib_rtl_pkg;

    typedef enum logic [1:0] {
        OpAdd    = 2'b00,
        OpSub    = 2'b01,
        OpAddSat = 2'b10,
        OpSubSat = 2'b11
    } op_e;

    localparam int unsigned LatencyMin = 1;
    localparam int unsigned LatencyMax = 4;
    localparam int unsigned WidthMin   = 8;
    localparam int unsigned WidthMax   = 64;

endpackage

// File: rtl/lib_rtl_pipe_stage.sv
// One pipeline register: valid bit plus payload, loaded only when the global enable is high.
module lib_rtl_pipe_stage #(
    parameter int unsigned PayloadWidth = 33
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    en,
    input  logic                    load_valid,
    input  logic [PayloadWidth-1:0] load_data,
    output logic                    valid,
    output logic [PayloadWidth-1:0] data
);

    logic                    valid_q;
    logic [PayloadWidth-1:0] data_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= load_valid;
            data_q  <= load_data;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/lib_rtl_addsub_pipe.sv
// Pipelined signed add/subtract with optional saturation, overflow flag and sticky overflow.
import lib_rtl_pkg::*;

module lib_rtl_addsub_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ivalid,
    output logic             oready,
    input  logic             iready,
    output logic             ovalid,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] datain1,
    input  logic [WIDTH-1:0] datain2,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] dataout,
    output logic             ovf,
    output logic             ovf_sticky
);

    if (WIDTH < WidthMin || WIDTH > WidthMax) begin : g_bad_width
        $fatal(1, "lib_rtl_addsub_pipe: WIDTH out of range");
    end
    if (LATENCY < LatencyMin || LATENCY > LatencyMax) begin : g_bad_latency
        $fatal(1, "lib_rtl_addsub_pipe: LATENCY out of range");
    end

    op_e                    op;
    logic                   is_sub;
    logic                   is_sat;
    logic signed [WIDTH:0]  a_ext;
    logic signed [WIDTH:0]  b_ext;
    logic signed [WIDTH:0]  sum_ext;
    logic                   overflow;
    logic [WIDTH-1:0]       result;
    logic [WIDTH:0]         head_data;
    logic                   en;
    logic                   stage_valid [LATENCY];
    logic [WIDTH:0]         stage_data  [LATENCY];
    logic                   sticky_q;
    logic                   sticky_d;

    assign op = op_e'(mode);

    // Overflow comes from the sign-extended WIDTH+1 sum: the top two bits disagree.
    always_comb begin
        is_sub = 1'b0;
        is_sat = 1'b0;
        unique case (op)
            OpAdd:    begin is_sub = 1'b0; is_sat = 1'b0; end
            OpSub:    begin is_sub = 1'b1; is_sat = 1'b0; end
            OpAddSat: begin is_sub = 1'b0; is_sat = 1'b1; end
            OpSubSat: begin is_sub = 1'b1; is_sat = 1'b1; end
            default:  begin is_sub = 1'b0; is_sat = 1'b0; end
        endcase

        a_ext    = {datain1[WIDTH-1], datain1};
        b_ext    = {datain2[WIDTH-1], datain2};
        sum_ext  = is_sub ? (a_ext - b_ext) : (a_ext + b_ext);
        overflow = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];

        if (is_sat && overflow) begin
            result = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            result = sum_ext[WIDTH-1:0];
        end

        // Bubbles carry zero payload so the output reads 0 whenever ovalid is low.
        head_data = ivalid ? {overflow, result} : '0;
    end

    assign en = !stage_valid[LATENCY-1] || iready;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        logic           load_valid;
        logic [WIDTH:0] load_data;

        if (i == 0) begin : g_head
            assign load_valid = ivalid;
            assign load_data  = head_data;
        end else begin : g_body
            assign load_valid = stage_valid[i-1];
            assign load_data  = stage_data[i-1];
        end

        lib_rtl_pipe_stage #(
            .PayloadWidth(WIDTH + 1)
        ) u_stage (
            .clock     (clock),
            .resetn    (resetn),
            .en        (en),
            .load_valid(load_valid),
            .load_data (load_data),
            .valid     (stage_valid[i]),
            .data      (stage_data[i])
        );
    end

    assign oready  = en;
    assign ovalid  = stage_valid[LATENCY-1];
    assign dataout = stage_data[LATENCY-1][WIDTH-1:0];
    assign ovf     = stage_data[LATENCY-1][WIDTH];

    // A delivered overflow wins over a concurrent clear.
    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (ovalid && iready && ovf) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;

endmodule

// File: doc/lib_rtl_addsub_pipe.md
LIB_RTL_ADDSUB_PIPE -- requirements
Module: lib_rtl_addsub_pipe

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH    32  operand/result width in bits, 8..64
  LATENCY  2   pipeline stages from acceptance to output, 1..4
REQ-002 Ports SHALL be, one per line:
  clock     in   1        single clock; all logic on its rising edge
  resetn    in   1        asynchronous, active-low reset
  ivalid    in   1        upstream data valid
  oready    out  1        block can accept this cycle
  iready    in   1        downstream can accept this cycle
  ovalid    out  1        dataout/ovf valid this cycle
  mode      in   2        op, sampled with operands: 00 ADD, 01 SUB, 10 ADD_SAT, 11 SUB_SAT
  datain1   in   WIDTH    operand A, two's complement
  datain2   in   WIDTH    operand B, two's complement
  clr_sticky in  1        synchronous clear of ovf_sticky
  dataout   out  WIDTH    result
  ovf       out  1        signed overflow of the delivered result
  ovf_sticky out 1        set by any delivered overflow, held until cleared
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low on resetn.

Function
REQ-004 Accept SHALL occur when ivalid && oready; deliver SHALL occur when ovalid && iready.
REQ-005 The pipeline SHALL have LATENCY register stages, each with a valid bit, advancing on a global enable en = !valid[LATENCY-1] || iready.
REQ-006 oready SHALL equal en (combinational; no combinational path from ivalid to oready).
REQ-007 With iready held high, a result accepted in cycle N SHALL appear with ovalid=1 in cycle N+LATENCY.
REQ-008 When en=0, all stages, ovalid, dataout and ovf SHALL hold; no item is lost, duplicated or reordered.
REQ-009 When ivalid=0 and en=1, a bubble (valid=0, data 0) SHALL enter stage 0; dataout and ovf SHALL be 0 whenever ovalid=0.
REQ-010 ADD/SUB SHALL produce the WIDTH-bit wrapped result of A+B / A-B; ovf=1 on signed overflow.
REQ-011 ADD_SAT/SUB_SAT SHALL clamp to 2^(WIDTH-1)-1 on positive overflow and -2^(WIDTH-1) on negative overflow; ovf=1 when clamped.
REQ-012 Overflow SHALL be computed in a WIDTH+1-bit signed intermediate in stage 0; later stages are pure delay.
REQ-013 ovf_sticky SHALL set in the cycle after a deliver with ovf=1; clr_sticky SHALL clear it; simultaneous set and clear SHALL leave it set.
REQ-014 mode SHALL be captured per item; changing mode mid-stream SHALL affect only newly accepted items.

Reset
REQ-015 On resetn low, all valid bits, dataout, ovf, ovf_sticky SHALL go to 0 immediately; ovalid=0; oready SHALL read 1 while in reset.
REQ-016 Reset mid-operation SHALL discard all in-flight items; the first accept after release SHALL appear after exactly LATENCY cycles.

Structure
REQ-017 Package lib_rtl_pkg SHALL hold the op_e enum (ADD, SUB, ADD_SAT, SUB_SAT) and the LATENCY min/max constants.
REQ-018 One sub-module lib_rtl_pipe_stage (valid + WIDTH+1-bit payload, enable, async reset) SHALL be instantiated LATENCY times via generate.
REQ-019 Illegal WIDTH or LATENCY SHALL fail elaboration.

Verification (WIDTH=32, LATENCY=2)
REQ-020 ADD 5+7, iready=1 -> ovalid in cycle N+2, dataout=12, ovf=0.
REQ-021 ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1; ADD_SAT same -> 0x7FFFFFFF, ovf=1; SUB_SAT 0x80000000-1 -> 0x80000000, ovf=1; SUB 3-5 -> 0xFFFFFFFE, ovf=0.
REQ-022 Stream 1,2,3,4 (+10), iready low 3 cycles mid-stream -> oready low while stage 1 full, outputs 11,12,13,14 in order, no duplicates.
REQ-023 ivalid alternating 1/0 -> ovalid alternating after 2 cycles, dataout=0 on bubble cycles.
REQ-024 resetn pulsed low with 2 items in flight -> ovalid=0 at once, items never delivered; next accept delivered 2 cycles later.
REQ-025 Overflowing deliver -> ovf_sticky=1 next cycle; clr_sticky with concurrent overflow -> stays 1; clr_sticky alone -> 0.
